// File: rtl/acc_share_ctrl.sv
// Round-robin burst controller sharing one accumulator among NUM_REQ requesters.
// A granted burst runs to completion, and its total is reported with a one-cycle done pulse.
module acc_share_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned ACC_WD  = 64,
    parameter int unsigned LEN_WD  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*LEN_WD-1:0]    i_len,
    input  logic [NUM_REQ-1:0]           i_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]   i_data,
    output logic [NUM_REQ-1:0]           o_gnt,
    output logic [NUM_REQ-1:0]           o_ready,
    output logic                         o_done,
    output logic [$clog2(NUM_REQ)-1:0]   o_done_id,
    output logic [ACC_WD-1:0]            o_sum,
    output logic                         o_ovf
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]      win_q, win_d;
    logic [LEN_WD-1:0]   len_q, len_d;
    logic [LEN_WD-1:0]   cnt_q, cnt_d;
    logic [ACC_WD-1:0]   acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [ACC_WD-1:0]   sum_q, sum_d;
    logic                ovf_out_q, ovf_out_d;
    logic [IdW-1:0]      done_id_q, done_id_d;

    logic [DATA_WD-1:0]  data_arr [NUM_REQ];
    logic [LEN_WD-1:0]   len_arr  [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr[k] = i_data[k*DATA_WD +: DATA_WD];
        assign len_arr[k]  = i_len[k*LEN_WD +: LEN_WD];
    end

    // Rotate the request vector so bit 0 is the requester at rr_ptr.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 arb_found;
    logic [IdW-1:0]       arb_idx;
    logic [IdW:0]         arb_cand;
    logic [IdW-1:0]       arb_next_ptr;

    assign req_dbl = {i_req, i_req};
    assign req_rot = req_dbl[rr_ptr_q +: NUM_REQ];

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req_rot[i]) begin
                arb_found = 1'b1;
                arb_cand  = {1'b0, rr_ptr_q} + (IdW+1)'(i);
                if (arb_cand >= (IdW+1)'(NUM_REQ)) begin
                    arb_cand = arb_cand - (IdW+1)'(NUM_REQ);
                end
                arb_idx = arb_cand[IdW-1:0];
            end
        end
    end

    assign arb_next_ptr = (arb_idx == IdW'(NUM_REQ - 1)) ? '0 : arb_idx + IdW'(1);

    logic                beat_acc;
    logic [DATA_WD-1:0]  beat_data;
    logic [ACC_WD:0]     add_ext;
    logic [LEN_WD-1:0]   cnt_inc;

    assign beat_acc  = (state_q == StAccum) && i_valid[win_q];
    assign beat_data = data_arr[win_q];
    assign add_ext   = {1'b0, acc_q} + (ACC_WD+1)'(beat_data);
    assign cnt_inc   = cnt_q + LEN_WD'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        ovf_out_d = ovf_out_q;
        done_id_d = done_id_q;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    win_d    = arb_idx;
                    len_d    = len_arr[arb_idx];
                    cnt_d    = '0;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    rr_ptr_d = arb_next_ptr;
                    if (len_arr[arb_idx] == '0) begin
                        // Empty burst reports a zero total without granting any beats.
                        state_d   = StDone;
                        sum_d     = '0;
                        ovf_out_d = 1'b0;
                        done_id_d = arb_idx;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (beat_acc) begin
                    acc_d = add_ext[ACC_WD-1:0];
                    ovf_d = ovf_q | add_ext[ACC_WD];
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d   = StDone;
                        sum_d     = add_ext[ACC_WD-1:0];
                        ovf_out_d = ovf_q | add_ext[ACC_WD];
                        done_id_d = win_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            ovf_out_q <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            ovf_out_q <= ovf_out_d;
            done_id_q <= done_id_d;
        end
    end

    logic [NUM_REQ-1:0] win_onehot;

    assign win_onehot = NUM_REQ'(1) << win_q;
    assign o_gnt      = (state_q != StIdle)  ? win_onehot : '0;
    assign o_ready    = (state_q == StAccum) ? win_onehot : '0;
    assign o_done     = (state_q == StDone);
    assign o_done_id  = done_id_q;
    assign o_sum      = sum_q;
    assign o_ovf      = ovf_out_q;

    a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt));
    a_ready_owner: assert property (@(posedge i_clk) disable iff (i_rst)
                                    (o_ready & ~o_gnt) == '0);
    a_done_gnt:    assert property (@(posedge i_clk) disable iff (i_rst)
                                    o_done |-> (o_gnt != '0) && (o_ready == '0));

endmodule

// File: tb/tb_acc_share_ctrl.sv
// Bench for acc_share_ctrl: directed scenarios plus randomized requester traffic,
// checked every cycle against a transaction-level reference model.
module tb_acc_share_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned LW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, valid, gnt, ready;
    logic [N*LW-1:0]   len;
    logic [N*DW-1:0]   data;
    logic              done, ovf;
    logic [1:0]        done_id;
    logic [AW-1:0]     sum;

    // Narrow instance where an 8-bit total can wrap.
    logic [1:0]        s_req, s_valid, s_gnt, s_ready;
    logic [15:0]       s_len, s_data;
    logic              s_done, s_ovf;
    logic [0:0]        s_done_id;
    logic [7:0]        s_sum;

    always #5 clk = ~clk;

    acc_share_ctrl #(.NUM_REQ(N), .DATA_WD(DW), .ACC_WD(AW), .LEN_WD(LW)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_len(len), .i_valid(valid), .i_data(data),
        .o_gnt(gnt), .o_ready(ready), .o_done(done), .o_done_id(done_id), .o_sum(sum),
        .o_ovf(ovf)
    );

    acc_share_ctrl #(.NUM_REQ(2), .DATA_WD(8), .ACC_WD(8), .LEN_WD(8)) u_small (
        .i_clk(clk), .i_rst(rst), .i_req(s_req), .i_len(s_len), .i_valid(s_valid),
        .i_data(s_data), .o_gnt(s_gnt), .o_ready(s_ready), .o_done(s_done),
        .o_done_id(s_done_id), .o_sum(s_sum), .o_ovf(s_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting beats, 2 reporting.
    int            m_phase = 0;
    int            m_ptr = 0, m_win = 0, m_len = 0, m_cnt = 0, m_id = 0;
    logic [127:0]  m_total = '0;
    logic [63:0]   m_sum = '0;
    bit            m_ovf = 1'b0;
    bit            m_fire, m_fin;

    task automatic model_finish();
        m_phase = 2;
        m_sum   = m_total[63:0];
        m_ovf   = |m_total[127:64];
        m_id    = m_win;
        m_fin   = 1'b1;
    endtask

    task automatic model_step();
        int found;
        int c;
        m_fire = 1'b0;
        m_fin  = 1'b0;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_win = 0; m_sum = '0; m_id = 0; m_ovf = 1'b0;
            return;
        end
        case (m_phase)
            0: begin
                found = -1;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (found < 0 && req[c]) found = c;
                end
                if (found >= 0) begin
                    m_win   = found;
                    m_len   = int'(len[found*LW +: LW]);
                    m_cnt   = 0;
                    m_total = '0;
                    m_ptr   = (found + 1) % N;
                    if (m_len == 0) model_finish();
                    else m_phase = 1;
                end
            end
            1: begin
                if (valid[m_win]) begin
                    m_total = m_total + 128'(data[m_win*DW +: DW]);
                    m_cnt++;
                    m_fire = 1'b1;
                    if (m_cnt == m_len) model_finish();
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        eg = (m_phase != 0) ? (N'(1) << m_win) : '0;
        er = (m_phase == 1) ? (N'(1) << m_win) : '0;
        check_eq("gnt", gnt, eg);
        check_eq("ready", ready, er);
        check_eq("done", done, m_phase == 2);
        check_eq("done_id", done_id, m_id);
        check_eq("sum", sum, m_sum);
        check_eq("ovf", ovf, m_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Random traffic agents.
    bit           on [N];
    int           alen [N];
    int           bi [N];
    logic [31:0]  bq [N][$];
    int           rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        int n_done;
        int last_t;
        logic [127:0] exp_tot;

        rst = 1'b1; req = '0; len = '0; valid = '0; data = '0;
        s_req = '0; s_len = '0; s_valid = '0; s_data = '0;
        cycle();
        rst = 1'b0;
        check_eq("rst_sum", sum, 0);
        check_eq("rst_gnt", gnt, 0);
        cycle();

        // Single burst 5,7,9.
        req = 4'b0001; len[0 +: LW] = 3; valid = 4'b0001; data[0 +: DW] = 5;
        cycle();
        check_eq("s1_gnt", gnt, 4'b0001);
        req = '0;
        cycle();
        data[0 +: DW] = 7; cycle();
        data[0 +: DW] = 9; cycle();
        check_eq("s1_done", done, 1);
        check_eq("s1_sum", sum, 21);
        check_eq("s1_id", done_id, 0);
        check_eq("s1_ovf", ovf, 0);
        valid = '0;
        cycle();
        check_eq("s1_hold", sum, 21);

        // Round-robin with all requesters held high.
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 4'hF; valid = 4'hF;
        for (int k = 0; k < N; k++) begin
            len[k*LW +: LW] = 1;
            data[k*DW +: DW] = 32'(k + 1);
        end
        n_done = 0; last_t = 0;
        for (int t = 1; t <= 15; t++) begin
            cycle();
            if (done && n_done < 5) begin
                check_eq("rr_id", done_id, rr_exp[n_done]);
                if (n_done > 0) check_eq("rr_gap", t - last_t, 3);
                last_t = t;
                n_done++;
            end
        end
        check_eq("rr_count", n_done, 5);
        req = '0;
        repeat (4) cycle();
        valid = '0;

        // Stall between beats.
        req = 4'b0010; len[1*LW +: LW] = 2; valid = 4'b0010; data[1*DW +: DW] = 10;
        cycle();
        req = '0;
        cycle();
        valid = '0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("st_ready", ready, 4'b0010);
            check_eq("st_nodone", done, 0);
        end
        valid = 4'b0010; data[1*DW +: DW] = 20;
        cycle();
        check_eq("st_done", done, 1);
        check_eq("st_sum", sum, 30);
        valid = '0;
        cycle();

        // Overflow and zero length on the narrow instance.
        s_req = 2'b01; s_len[7:0] = 2; s_valid = 2'b01; s_data[7:0] = 200;
        cycle();
        s_req = '0;
        cycle();
        s_data[7:0] = 100;
        cycle();
        check_eq("ov_done", s_done, 1);
        check_eq("ov_sum", s_sum, 44);
        check_eq("ov_ovf", s_ovf, 1);
        s_valid = '0;
        cycle();
        s_req = 2'b01; s_len[7:0] = 0;
        cycle();
        check_eq("z_done", s_done, 1);
        check_eq("z_sum", s_sum, 0);
        check_eq("z_ovf", s_ovf, 0);
        check_eq("z_ready", s_ready, 0);
        s_req = '0;
        cycle();
        check_eq("z_pulse", s_done, 0);

        // Reset in the middle of a burst.
        req = 4'b0100; len[2*LW +: LW] = 4; valid = 4'b0100; data[2*DW +: DW] = 3;
        cycle();
        req = '0;
        cycle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("mr_gnt", gnt, 0);
        check_eq("mr_ready", ready, 0);
        check_eq("mr_done", done, 0);
        check_eq("mr_sum", sum, 0);
        check_eq("mr_id", done_id, 0);
        check_eq("mr_ovf", ovf, 0);
        valid = '0;
        cycle();
        check_eq("mr_nodone", done, 0);
        req = 4'hF;
        for (int k = 0; k < N; k++) len[k*LW +: LW] = 1;
        cycle();
        check_eq("mr_win0", gnt, 4'b0001);
        req = '0; valid = 4'hF;
        repeat (4) cycle();

        // Non-owner isolation.
        req = 4'b0100; len[2*LW +: LW] = 3; valid = 4'b0111;
        data[0 +: DW] = 32'hFFFF; data[1*DW +: DW] = 32'hFFFF;
        cycle();
        req = '0;
        for (int b = 1; b <= 3; b++) begin
            data[2*DW +: DW] = 32'(b);
            check_eq("iso_ready", ready[1:0], 0);
            cycle();
        end
        check_eq("iso_done", done, 1);
        check_eq("iso_sum", sum, 6);
        valid = '0;
        cycle();

        // Randomized traffic with occasional resets.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int k = 0; k < N; k++) begin on[k] = 1'b0; alen[k] = 0; bi[k] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < N; k++) begin
                if (!on[k] && $urandom_range(0, 3) == 0) begin
                    on[k]   = 1'b1;
                    alen[k] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
                    bq[k].delete();
                    for (int j = 0; j < alen[k]; j++) bq[k].push_back($urandom);
                    bi[k] = 0;
                end
                req[k] = on[k];
                len[k*LW +: LW] = LW'(alen[k]);
                if (m_phase == 1 && m_win == k) begin
                    valid[k] = ($urandom_range(0, 9) < 7);
                    data[k*DW +: DW] = (bi[k] < bq[k].size()) ? bq[k][bi[k]] : 32'h0;
                end else begin
                    valid[k] = $urandom_range(0, 1) != 0;
                    data[k*DW +: DW] = $urandom;
                end
            end
            cycle();
            if (rst) begin
                for (int k = 0; k < N; k++) on[k] = 1'b0;
            end else begin
                if (m_fire) bi[m_win]++;
                if (m_fin) begin
                    exp_tot = '0;
                    foreach (bq[m_id][j]) exp_tot = exp_tot + 128'(bq[m_id][j]);
                    check_eq("sb_sum", sum, exp_tot[63:0]);
                    check_eq("sb_id", done_id, m_id);
                    on[m_id] = 1'b0;
                end
            end
        end
        rst = 1'b0; req = '0; valid = '0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_share_ctrl.md
# acc_share_ctrl

Burst controller that shares a single accumulation datapath between NUM_REQ requesters. It round-robin arbitrates burst requests, streams the winner's data beats through an internal accumulator, and returns the total with a one-cycle done pulse. It sits between the requester ports and the common accumulator resource. Software-visible bursts never interleave.

## Interface
- NUM_REQ, 4: number of requesters (≥2).
- DATA_WD, 32: width of each data beat.
- ACC_WD, 64: accumulator/result width (≥ DATA_WD).
- LEN_WD, 8: burst-length field width.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_req  in  NUM_REQ  per-requester burst request (level).
- i_len  in  NUM_REQ*LEN_WD  per-requester beat count, requester k at bits [k*LEN_WD +: LEN_WD].
- i_valid  in  NUM_REQ  per-requester data valid.
- i_data  in  NUM_REQ*DATA_WD  per-requester data, packed as i_len.
- o_gnt  out  NUM_REQ  one-hot grant to the current burst owner.
- o_ready  out  NUM_REQ  beat acceptance; only the owner's bit can be 1.
- o_done  out  1  one-cycle pulse, result valid.
- o_done_id  out  $clog2(NUM_REQ)  index of the finished requester.
- o_sum  out  ACC_WD  burst total.
- o_ovf  out  1  burst total wrapped past 2^ACC_WD.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: o_gnt=0, o_ready=0. If any i_req bit is set, pick the winner by round-robin starting at pointer rr_ptr. Latch winner index and i_len[winner], clear acc, clear ovf, set rr_ptr=(winner+1) mod NUM_REQ.
  - If the latched len is nonzero, go to ACCUM.
  - If the latched len is 0, go directly to DONE with sum 0.
- ACCUM: o_gnt[win]=1 and o_ready[win]=1.
  - Beat accepted when i_valid[win] & o_ready[win] at a rising edge.
  - On accept: acc <= acc + zero-extended i_data[win], beat count +1, ovf |= carry-out.
  - When the accepted beat is beat number len, go to DONE.
  - Valid low stalls indefinitely; no timeout.
  - i_valid and i_data of non-owners are ignored.
- DONE (one cycle): o_done=1, o_done_id=win, o_sum=acc, o_ovf=ovf, o_gnt[win] still 1, o_ready=0. Next state is IDLE.
- i_req is sampled only in IDLE. Deasserting req during ACCUM does not abort the burst. A requester that keeps req high re-enters arbitration after its DONE.
- Arithmetic: unsigned; sum is modulo 2^ACC_WD; o_ovf is sticky within the burst.
- o_sum, o_done_id and o_ovf hold their last values outside DONE. Only o_done qualifies them.

## Timing
- Reset (i_rst high at an edge): state=IDLE, rr_ptr=0, acc=0, count=0, o_gnt=0, o_ready=0, o_done=0, o_done_id=0, o_sum=0, o_ovf=0. Takes effect at the next edge.
- Reset asserted mid-burst abandons the burst and produces no o_done.
- Latency: req seen in IDLE cycle 0 → grant/ready in cycle 1. With no stalls, the last beat is in cycle len and o_done is in cycle len+1. For len=0, o_done is in cycle 1.
- Minimum spacing between bursts: 1 IDLE cycle after DONE. Back-to-back throughput is len+2 cycles per burst.
- All outputs are registered or decoded from registered state. No combinational path from i_* to o_*.
- Simultaneous requests: the lowest index at or after rr_ptr (modulo NUM_REQ) wins.

## Test plan
- Single burst: reset, then i_req=0001, i_len[0]=3, data 5,7,9 with valid held high → o_gnt=0001 in cycle 1, o_done in cycle 4 with o_sum=21, o_done_id=0, o_ovf=0.
- Round-robin: i_req=1111 held, all len=1, data k+1 → o_done_id sequence 0,1,2,3,0; each o_done is 3 cycles apart.
- Stall: len=2, valid low for 5 cycles between beats 10 and 20 → o_ready stays high, o_done arrives 5 cycles later, o_sum=30.
- Overflow/zero length: ACC_WD=DATA_WD=8 with beats 200,100 → o_sum=44, o_ovf=1. A len=0 request → o_done in cycle 1, o_sum=0, o_ovf=0.
- Reset mid-burst: assert i_rst after 2 of 4 beats → all outputs 0 next cycle, no o_done, rr_ptr=0. Requester 0 then wins first.
- Non-owner isolation: requester 2 bursting while requesters 0 and 1 drive valid with data 0xFFFF → o_ready[1:0]=0 and o_sum is unaffected.
